// File: rtl/riscv_rf_wb_ctrl_if.sv
// rtl/riscv_rf_wb_ctrl_if.sv - bus interface of the register-file write-back controller
//
// Purpose : bundles every producer, issue, decode and register-file signal of
//           riscv_rf_wb_ctrl so the controller takes a single bus port.
// Modports: slave  - controller view (producers/decode in, RF writes out)
//           master - environment view (drives producers/decode, observes RF writes)
// Signals : alu_*  single-cycle ALU result        lsu_*   load result (ready = FIFO not full)
//           md_*   mult/div result (ready = grant) issue_* long-latency issue destination
//           raddr_*/hazard_*  decode read ports    waddr/wdata/we_{a,b}  RF write ports
//           pending_o scoreboard vector
// Option  : RF_WB_WAW_CHECK_EN adds the sticky waw_err_o flag.
interface riscv_rf_wb_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   localparam int NUM_WORDS = 2**ADDR_WIDTH;

   logic                  alu_valid_i;
   logic [ADDR_WIDTH-1:0] alu_waddr_i;
   logic [DATA_WIDTH-1:0] alu_wdata_i;
   logic                  lsu_valid_i;
   logic                  lsu_ready_o;
   logic [ADDR_WIDTH-1:0] lsu_waddr_i;
   logic [DATA_WIDTH-1:0] lsu_wdata_i;
   logic                  md_valid_i;
   logic                  md_ready_o;
   logic [ADDR_WIDTH-1:0] md_waddr_i;
   logic [DATA_WIDTH-1:0] md_wdata_i;
   logic                  issue_valid_i;
   logic [ADDR_WIDTH-1:0] issue_waddr_i;
   logic [ADDR_WIDTH-1:0] raddr_a_i;
   logic [ADDR_WIDTH-1:0] raddr_b_i;
   logic [ADDR_WIDTH-1:0] raddr_c_i;
   logic                  hazard_a_o;
   logic                  hazard_b_o;
   logic                  hazard_c_o;
   logic [ADDR_WIDTH-1:0] waddr_a_o;
   logic [DATA_WIDTH-1:0] wdata_a_o;
   logic                  we_a_o;
   logic [ADDR_WIDTH-1:0] waddr_b_o;
   logic [DATA_WIDTH-1:0] wdata_b_o;
   logic                  we_b_o;
   logic [NUM_WORDS-1:0]  pending_o;
`ifdef RF_WB_WAW_CHECK_EN
   logic                  waw_err_o;
`endif

   modport slave (
      input  alu_valid_i, alu_waddr_i, alu_wdata_i,
      input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
      input  md_valid_i, md_waddr_i, md_wdata_i,
      input  issue_valid_i, issue_waddr_i,
      input  raddr_a_i, raddr_b_i, raddr_c_i,
`ifdef RF_WB_WAW_CHECK_EN
      output waw_err_o,
`endif
      output lsu_ready_o, md_ready_o,
      output hazard_a_o, hazard_b_o, hazard_c_o,
      output waddr_a_o, wdata_a_o, we_a_o,
      output waddr_b_o, wdata_b_o, we_b_o,
      output pending_o
   );

   modport master (
      output alu_valid_i, alu_waddr_i, alu_wdata_i,
      output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
      output md_valid_i, md_waddr_i, md_wdata_i,
      output issue_valid_i, issue_waddr_i,
      output raddr_a_i, raddr_b_i, raddr_c_i,
`ifdef RF_WB_WAW_CHECK_EN
      input  waw_err_o,
`endif
      input  lsu_ready_o, md_ready_o,
      input  hazard_a_o, hazard_b_o, hazard_c_o,
      input  waddr_a_o, wdata_a_o, we_a_o,
      input  waddr_b_o, wdata_b_o, we_b_o,
      input  pending_o
   );
endinterface

// File: rtl/riscv_rf_wb_ctrl.sv
// rtl/riscv_rf_wb_ctrl.sv - write-back controller for both RF write ports
//
// Purpose : port A registers single-cycle ALU results; port B arbitrates
//           between a load-result FIFO and the mult/div unit (LSU first, MD
//           forced through after MD_MAX_WAIT consecutive LSU grants); a
//           per-register pending scoreboard flags decode read hazards.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset
//           bus   - riscv_rf_wb_ctrl_if.slave (producers, issue, decode
//                   read addresses, RF write ports A/B, scoreboard)
// Option  : RF_WB_WAW_CHECK_EN - adds sticky bus.waw_err_o for double issue
//           to a pending register and for port-B writes to non-pending ones.
module riscv_rf_wb_ctrl #(
   parameter int ADDR_WIDTH     = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int LSU_FIFO_DEPTH = 2,
   parameter int MD_MAX_WAIT    = 4
) (
   input logic                clk,
   input logic                rst_n,
   riscv_rf_wb_ctrl_if.slave  bus
);
   localparam int NUM_WORDS = 2**ADDR_WIDTH;
   localparam int PTR_W     = $clog2(LSU_FIFO_DEPTH);
   localparam int CNT_W     = $clog2(LSU_FIFO_DEPTH + 1);
   localparam int AGE_W     = $clog2(MD_MAX_WAIT + 1);

   // port A
   logic                  r_we_a;
   logic [ADDR_WIDTH-1:0] r_waddr_a;
   logic [DATA_WIDTH-1:0] r_wdata_a;

   // load FIFO
   logic [ADDR_WIDTH-1:0] r_fifo_addr [LSU_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_data [LSU_FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;

   // port B
   logic [AGE_W-1:0]      r_age;
   logic                  r_we_b;
   logic [ADDR_WIDTH-1:0] r_waddr_b;
   logic [DATA_WIDTH-1:0] r_wdata_b;

   logic [NUM_WORDS-1:0]  r_pending;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_md_grant;
   logic                  w_lsu_grant;
   logic                  w_grant;
   logic [ADDR_WIDTH-1:0] w_gnt_addr;
   logic [DATA_WIDTH-1:0] w_gnt_data;
   logic                  w_issue;
   logic [NUM_WORDS-1:0]  w_clr_vec;
   logic [NUM_WORDS-1:0]  w_set_vec;
   logic [NUM_WORDS-1:0]  w_pending_nxt;

   assign w_full  = (r_count == CNT_W'(LSU_FIFO_DEPTH));
   assign w_empty = (r_count == '0);

   // Ready comes only from the occupancy register, so a pop on a full FIFO
   // does not reopen the slot until the following cycle.
   assign w_push = bus.lsu_valid_i && !w_full;

   assign w_md_grant  = bus.md_valid_i && (w_empty || (r_age == AGE_W'(MD_MAX_WAIT)));
   assign w_lsu_grant = !w_empty && !w_md_grant;
   assign w_grant     = w_md_grant || w_lsu_grant;
   assign w_gnt_addr  = w_md_grant ? bus.md_waddr_i : r_fifo_addr[r_rptr];
   assign w_gnt_data  = w_md_grant ? bus.md_wdata_i : r_fifo_data[r_rptr];

   assign w_issue   = bus.issue_valid_i && (bus.issue_waddr_i != '0);
   assign w_clr_vec = w_grant ? (NUM_WORDS'(1) << w_gnt_addr) : '0;
   assign w_set_vec = w_issue ? (NUM_WORDS'(1) << bus.issue_waddr_i) : '0;
   // Set is applied after clear so a same-address collision leaves the bit set.
   assign w_pending_nxt = ((r_pending & ~w_clr_vec) | w_set_vec) & ~NUM_WORDS'(1);

   // FIFO storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wptr] <= bus.lsu_waddr_i;
         r_fifo_data[r_wptr] <= bus.lsu_wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we_a    <= 1'b0;
         r_waddr_a <= '0;
         r_wdata_a <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_age     <= '0;
         r_we_b    <= 1'b0;
         r_waddr_b <= '0;
         r_wdata_b <= '0;
         r_pending <= '0;
      end else begin
         r_we_a <= bus.alu_valid_i && (bus.alu_waddr_i != '0);
         if (bus.alu_valid_i) begin
            r_waddr_a <= bus.alu_waddr_i;
            r_wdata_a <= bus.alu_wdata_i;
         end

         // Depth is a power of two, so natural pointer overflow wraps correctly.
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_lsu_grant) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_lsu_grant})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase

         // An LSU grant while MD waits implies r_age < MD_MAX_WAIT, so the
         // increment saturates by construction.
         if (w_md_grant || !bus.md_valid_i) begin
            r_age <= '0;
         end else if (w_lsu_grant) begin
            r_age <= r_age + AGE_W'(1);
         end

         r_we_b <= w_grant && (w_gnt_addr != '0);
         if (w_grant) begin
            r_waddr_b <= w_gnt_addr;
            r_wdata_b <= w_gnt_data;
         end

         r_pending <= w_pending_nxt;
      end
   end

`ifdef RF_WB_WAW_CHECK_EN
   logic r_waw_err;
   logic w_waw_issue;
   logic w_waw_grant;

   assign w_waw_issue = w_issue && r_pending[bus.issue_waddr_i] && !w_clr_vec[bus.issue_waddr_i];
   // Writes to x0 are legal discards and never count as an unmatched clear.
   assign w_waw_grant = w_grant && (w_gnt_addr != '0) && !r_pending[w_gnt_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waw_err <= 1'b0;
      end else if (w_waw_issue || w_waw_grant) begin
         r_waw_err <= 1'b1;
      end
   end

   assign bus.waw_err_o = r_waw_err;
`endif

   assign bus.lsu_ready_o = !w_full;
   assign bus.md_ready_o  = w_md_grant;
   assign bus.hazard_a_o  = r_pending[bus.raddr_a_i];
   assign bus.hazard_b_o  = r_pending[bus.raddr_b_i];
   assign bus.hazard_c_o  = r_pending[bus.raddr_c_i];
   assign bus.we_a_o      = r_we_a;
   assign bus.waddr_a_o   = r_waddr_a;
   assign bus.wdata_a_o   = r_wdata_a;
   assign bus.we_b_o      = r_we_b;
   assign bus.waddr_b_o   = r_waddr_b;
   assign bus.wdata_b_o   = r_wdata_b;
   assign bus.pending_o   = r_pending;
endmodule
